seq_step_controller: RTL and testbench

Parametrised successor to the fixed five-step pause/restart sequencer. The step count, output width and per-step output values are set by parameters. The block adds loop (wrap) mode, reverse stepping, a parametrised jump target and a saturating pass counter. It drives the step-indexed output patterns consumed by the display/test-pattern logic. Every output is a registered, one-cycle-delayed image of the internal step state.

---
 rtl/seq_step_controller.sv | 92 +++++++++
 tb/tb_seq_step_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_step_controller.sv
// seq_step_controller: parametrised step sequencer with optional wrap, reverse
// stepping, a jump-from-last-step target and a saturating pass counter.
// All outputs are registered images of the internal step state, one edge late.
module seq_step_controller #(
  parameter int                           NUM_STEPS  = 5,
  parameter int                           OUT_W      = 3,
  parameter int                           JUMP_STEP  = 2,
  parameter logic [NUM_STEPS*OUT_W-1:0]   OUT1_TABLE = {3'd5, 3'd6, 3'd2, 3'd5, 3'd3},
  parameter logic [NUM_STEPS*OUT_W-1:0]   OUT2_TABLE = {3'd2, 3'd3, 3'd7, 3'd4, 3'd2},
  parameter bit                           LOOP       = 1'b0,
  localparam int                          IW         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             restart_i,
  input  logic             pause_i,
  input  logic             jump_i,
  input  logic             reverse_i,
  output logic [IW-1:0]    step_o,
  output logic             terminal_o,
  output logic [OUT_W-1:0] out1_o,
  output logic [OUT_W-1:0] out2_o,
  output logic             even_o,
  output logic             odd_o,
  output logic [7:0]       pass_count_o
);

  localparam logic [IW-1:0] LAST = IW'(NUM_STEPS - 1);
  localparam logic [IW-1:0] JMP  = IW'(JUMP_STEP);

  logic [IW-1:0] cur_q, cur_d, cur_eff;
  logic [7:0]    passes_q, passes_d;
  logic          wrap;

  // Next-state selection: restart, jump-at-last, pause, then directional step/wrap.
  always_comb begin
    // Out-of-range indices (non power-of-two step counts) behave as step 0.
    cur_eff  = (cur_q > LAST) ? '0 : cur_q;
    cur_d    = cur_eff;
    passes_d = passes_q;
    wrap     = 1'b0;
    if (restart_i) begin
      cur_d    = '0;
      passes_d = '0;
    end else if (jump_i && (cur_eff == LAST)) begin
      cur_d = JMP;
    end else if (!pause_i) begin
      if (!reverse_i) begin
        if (cur_eff != LAST) begin
          cur_d = cur_eff + 1'b1;
        end else if (LOOP) begin
          cur_d = '0;
          wrap  = 1'b1;
        end
      end else begin
        if (cur_eff != '0) begin
          cur_d = cur_eff - 1'b1;
        end else if (LOOP) begin
          cur_d = LAST;
          wrap  = 1'b1;
        end
      end
      if (wrap && (passes_q != 8'hFF)) passes_d = passes_q + 8'd1;
    end
  end

  // Step state plus output image of the pre-edge state; reset loads step-0 values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q        <= '0;
      passes_q     <= '0;
      step_o       <= '0;
      terminal_o   <= (LAST == '0);
      out1_o       <= OUT1_TABLE[OUT_W-1:0];
      out2_o       <= OUT2_TABLE[OUT_W-1:0];
      odd_o        <= 1'b1;
      even_o       <= 1'b0;
      pass_count_o <= '0;
    end else begin
      cur_q        <= cur_d;
      passes_q     <= passes_d;
      step_o       <= cur_eff;
      terminal_o   <= (cur_eff == LAST);
      out1_o       <= OUT1_TABLE[int'(cur_eff)*OUT_W +: OUT_W];
      out2_o       <= OUT2_TABLE[int'(cur_eff)*OUT_W +: OUT_W];
      odd_o        <= ~cur_eff[0];
      even_o       <= cur_eff[0];
      pass_count_o <= passes_q;
    end
  end

endmodule

// File: tb/tb_seq_step_controller.sv
// Bench for seq_step_controller: three instances (default hold, 3-step loop,
// 5-step loop) driven with shared inputs, checked against a rule-level model,
// plus a vector table for the default instance and hand-written corner cases.
module tb_seq_step_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rs, pa, ju, rv;

  logic [2:0] a_st, c_st; logic [1:0] b_st;
  logic [2:0] a_o1, a_o2, b_o1, b_o2, c_o1, c_o2;
  logic       a_tm, a_ev, a_od, b_tm, b_ev, b_od, c_tm, c_ev, c_od;
  logic [7:0] a_pc, b_pc, c_pc;

  seq_step_controller dA (
    .clk_i(clk), .reset_i(rst), .restart_i(rs), .pause_i(pa), .jump_i(ju), .reverse_i(rv),
    .step_o(a_st), .terminal_o(a_tm), .out1_o(a_o1), .out2_o(a_o2),
    .even_o(a_ev), .odd_o(a_od), .pass_count_o(a_pc));

  seq_step_controller #(
    .NUM_STEPS(3), .OUT1_TABLE({3'd2, 3'd5, 3'd3}), .OUT2_TABLE({3'd7, 3'd4, 3'd2}), .LOOP(1'b1)
  ) dB (
    .clk_i(clk), .reset_i(rst), .restart_i(rs), .pause_i(pa), .jump_i(ju), .reverse_i(rv),
    .step_o(b_st), .terminal_o(b_tm), .out1_o(b_o1), .out2_o(b_o2),
    .even_o(b_ev), .odd_o(b_od), .pass_count_o(b_pc));

  seq_step_controller #(.LOOP(1'b1)) dC (
    .clk_i(clk), .reset_i(rst), .restart_i(rs), .pause_i(pa), .jump_i(ju), .reverse_i(rv),
    .step_o(c_st), .terminal_o(c_tm), .out1_o(c_o1), .out2_o(c_o2),
    .even_o(c_ev), .odd_o(c_od), .pass_count_o(c_pc));

  int checks = 0, errors = 0;

  // Reference model: per instance step count, wrap mode and value tables.
  int    NS [3] = '{5, 3, 5};
  bit    LP [3] = '{1'b0, 1'b1, 1'b1};
  string NM [3] = '{"A", "B", "C"};
  int    T1 [5] = '{3, 5, 2, 6, 5};
  int    T2 [5] = '{2, 4, 7, 3, 2};
  int    m_cur [3], m_pas [3], e_st [3], e_pc [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit j, input bit v);
    rst = r; rs = s; pa = p; ju = j; rv = v;
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cur[i] = 0; m_pas[i] = 0; e_st[i] = 0; e_pc[i] = 0;
      end else begin
        e_st[i] = m_cur[i];
        e_pc[i] = m_pas[i];
        if (rs) begin
          m_cur[i] = 0; m_pas[i] = 0;
        end else if (ju && m_cur[i] == NS[i] - 1) begin
          m_cur[i] = 2;
        end else if (!pa) begin
          int nxt;
          nxt = rv ? m_cur[i] - 1 : m_cur[i] + 1;
          if (nxt >= 0 && nxt < NS[i]) m_cur[i] = nxt;
          else if (LP[i]) begin
            m_cur[i] = (nxt < 0) ? NS[i] - 1 : 0;
            if (m_pas[i] < 255) m_pas[i]++;
          end
        end
      end
    end
  endtask

  task automatic cmp(input int i, input int st, input int tm, input int o1, input int o2,
                     input int ev, input int od, input int pc);
    int s;
    s = e_st[i];
    chk({NM[i], ".step"},     st, s);
    chk({NM[i], ".terminal"}, tm, (s == NS[i] - 1) ? 1 : 0);
    chk({NM[i], ".out1"},     o1, T1[s]);
    chk({NM[i], ".out2"},     o2, T2[s]);
    chk({NM[i], ".even"},     ev, s % 2);
    chk({NM[i], ".odd"},      od, 1 - s % 2);
    chk({NM[i], ".pass"},     pc, e_pc[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    cmp(0, a_st, a_tm, a_o1, a_o2, a_ev, a_od, a_pc);
    cmp(1, b_st, b_tm, b_o1, b_o2, b_ev, b_od, b_pc);
    cmp(2, c_st, c_tm, c_o1, c_o2, c_ev, c_od, c_pc);
  endtask

  typedef struct {
    bit rst, rs, pa, ju, rv;
    int st, o1, o2, tm, od, pc;
  } vec_t;
  vec_t tv [25];

  initial begin
    // Default instance: inputs applied at an edge, expected outputs after it.
    tv[0]  = '{1,0,0,0,0, 0,3,2,0,1,0};
    tv[1]  = '{0,0,0,0,0, 0,3,2,0,1,0};
    tv[2]  = '{0,0,0,0,0, 1,5,4,0,0,0};
    tv[3]  = '{0,0,0,0,0, 2,2,7,0,1,0};
    tv[4]  = '{0,0,0,0,0, 3,6,3,0,0,0};
    tv[5]  = '{0,0,0,0,0, 4,5,2,1,1,0};
    tv[6]  = '{0,0,0,0,0, 4,5,2,1,1,0};
    tv[7]  = '{0,0,1,1,0, 4,5,2,1,1,0};
    tv[8]  = '{0,0,0,0,0, 2,2,7,0,1,0};
    tv[9]  = '{0,0,0,0,0, 3,6,3,0,0,0};
    tv[10] = '{0,0,0,0,0, 4,5,2,1,1,0};
    tv[11] = '{0,1,0,0,0, 4,5,2,1,1,0};
    tv[12] = '{0,0,0,0,0, 0,3,2,0,1,0};
    tv[13] = '{0,0,1,0,0, 1,5,4,0,0,0};
    tv[14] = '{0,0,1,0,0, 1,5,4,0,0,0};
    tv[15] = '{0,0,1,0,0, 1,5,4,0,0,0};
    tv[16] = '{0,0,1,0,0, 1,5,4,0,0,0};
    tv[17] = '{0,1,1,0,0, 1,5,4,0,0,0};
    tv[18] = '{0,0,1,0,0, 0,3,2,0,1,0};
    tv[19] = '{0,0,0,0,0, 0,3,2,0,1,0};
    tv[20] = '{0,0,0,0,0, 1,5,4,0,0,0};
    tv[21] = '{0,0,0,0,0, 2,2,7,0,1,0};
    tv[22] = '{0,1,0,1,1, 3,6,3,0,0,0};
    tv[23] = '{0,0,0,0,1, 0,3,2,0,1,0};
    tv[24] = '{0,0,0,0,1, 0,3,2,0,1,0};

    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin m_cur[i] = 0; m_pas[i] = 0; e_st[i] = 0; e_pc[i] = 0; end
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      drive(tv[i].rst, tv[i].rs, tv[i].pa, tv[i].ju, tv[i].rv);
      cycle();
      chk($sformatf("vec%0d.step", i), a_st, tv[i].st);
      chk($sformatf("vec%0d.out1", i), a_o1, tv[i].o1);
      chk($sformatf("vec%0d.out2", i), a_o2, tv[i].o2);
      chk($sformatf("vec%0d.term", i), a_tm, tv[i].tm);
      chk($sformatf("vec%0d.odd", i),  a_od, tv[i].od);
      chk($sformatf("vec%0d.even", i), a_ev, 1 - tv[i].od);
      chk($sformatf("vec%0d.pass", i), a_pc, tv[i].pc);
    end

    // 3-step loop: three wraps after ten idle edges, then saturation and clear.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    chk("loop3.pass_after_wraps", b_pc, 3);
    chk("loop3.step_after_wraps", b_st, 0);
    for (int i = 0; i < 900; i++) cycle();
    chk("loop3.pass_saturated", b_pc, 255);
    drive(0, 1, 0, 0, 0); cycle();
    chk("loop3.pass_before_clear", b_pc, 255);
    drive(0, 0, 0, 0, 0); cycle();
    chk("loop3.pass_cleared", b_pc, 0);
    chk("loop3.step_cleared", b_st, 0);

    // Reverse from reset: wrap to the last step on the loop instance, hold otherwise.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    chk("rev.first_edge_step", c_st, 0);
    cycle();
    chk("rev.wrap_step", c_st, 4);
    chk("rev.wrap_pass", c_pc, 1);
    chk("rev.wrap_term", c_tm, 1);
    cycle();
    chk("rev.step3", c_st, 3);
    cycle();
    chk("rev.step2", c_st, 2);
    chk("rev.hold_noloop", a_st, 0);

    // Reset with pause at step 3 lands on step 0 at that very edge.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("rstmid.before", a_st, 3);
    drive(1, 0, 1, 0, 0); cycle();
    chk("rstmid.step", a_st, 0);
    chk("rstmid.out1", a_o1, 3);
    chk("rstmid.odd", a_od, 1);
    drive(0, 0, 0, 0, 0); cycle();
    chk("rstmid.resume0", a_st, 0);
    cycle();
    chk("rstmid.resume1", a_st, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
